// File: rtl/chksum_pkg.sv
// ============================================================================
// Module   : chksum_pkg
// Brief    : Shared state encoding and default widths for the checksum stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package chksum_pkg;

  localparam int unsigned c_def_width = 16;
  localparam int unsigned c_def_len_w = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/chksum_add_xor.sv
// ============================================================================
// Module   : chksum_add_xor
// Brief    : Combinational XOR and add-with-carry step feeding the accumulators.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module chksum_add_xor
  import chksum_pkg::*;
#(
  parameter int WIDTH = c_def_width
) (
  input  logic [WIDTH-1:0] a_xor_i,
  input  logic [WIDTH-1:0] a_sum_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] xor_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  assign xor_o            = a_xor_i ^ b_i;
  assign {carry_o, sum_o} = {1'b0, a_sum_i} + {1'b0, b_i};

endmodule

`default_nettype wire

// File: rtl/chksum_accumulator.sv
// ============================================================================
// Module   : chksum_accumulator
// Brief    : Frame-based XOR / sum / sticky-carry accumulator with handshakes.
//            Optional macro CHKSUM_CARRY_CNT_EN adds a saturating carry count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module chksum_accumulator
  import chksum_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int LEN_W = c_def_len_w
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
`ifdef CHKSUM_CARRY_CNT_EN
  output logic [LEN_W-1:0] out_carry_cnt,
`endif
  output logic             busy
);

  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic [WIDTH-1:0] xor_q, sum_q;
  logic [WIDTH-1:0] xor_d, sum_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             beat;

  assign beat = in_valid && in_ready_q;

  chksum_add_xor #(.WIDTH(WIDTH)) u_add_xor (
    .a_xor_i (xor_q),
    .a_sum_i (sum_q),
    .b_i     (in_data),
    .xor_o   (xor_d),
    .sum_o   (sum_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      xor_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            xor_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            if (frame_len != '0) begin
              remaining_q <= frame_len;
              in_ready_q  <= 1'b1;
              state_q     <= ACCUM;
            end else begin
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            xor_q       <= xor_d;
            sum_q       <= sum_d;
            carry_q     <= carry_q | carry_d;
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef CHKSUM_CARRY_CNT_EN
  logic [LEN_W-1:0] carry_cnt_q;

  // Saturates so a long frame of carries never wraps back to a small count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      carry_cnt_q <= '0;
    end else if (beat && carry_d && carry_cnt_q != {LEN_W{1'b1}}) begin
      carry_cnt_q <= carry_cnt_q + LEN_W'(1);
    end
  end

  assign out_carry_cnt = carry_cnt_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_xor   = xor_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;

endmodule

`default_nettype wire
